imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the combinational-read instruction memory of the RISC-V core.
- Owns the program counter and drives the memory's word address.
- Captures returned instruction words into a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush) and halts on misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, byte-address PC loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, fetch buffer entries; legal values 2 or 4.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_enable  input  1  high allows new fetches; low stops fetching, buffer still drains.
- redirect_valid  input  1  one-cycle pulse; replace PC with redirect_pc and flush buffer.
- redirect_pc  input  32  byte-address redirect target.
- imem_rstn  output  1  memory reset, combinational ~rst.
- imem_addr  output  32  word index to memory, combinational {2'b00, pc[31:2]}.
- imem_rdata  input  32  combinational read data for imem_addr in the same cycle.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode accepts head when instr_valid && instr_ready.
- instr  output  32  FIFO head instruction word.
- instr_pc  output  32  byte PC of FIFO head.
- misalign_err  output  1  sticky; set by redirect_pc[1:0] != 0.

Behaviour:
- Reset (rst high at an edge):
  - pc = RESET_PC; FIFO count = 0; state = IDLE.
  - instr_valid = 0, instr = 0, instr_pc = 0, misalign_err = 0.
  - Reset mid-operation discards all buffered entries.
- States:
  - IDLE: no push. Goes to FETCH when fetch_enable = 1.
  - FETCH: push allowed. Goes to IDLE when fetch_enable = 0; pc is held.
  - HALT: no push. Entered from any state on a misaligned redirect. Left only by rst or an aligned redirect, which goes to FETCH if fetch_enable = 1, else IDLE.
- Push condition, FETCH only, no redirect this cycle:
  - Buffer has space: count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop in the same cycle.
  - At the edge, {pc, imem_rdata} is written to the tail and pc <= pc + 4.
  - pc wraps mod 2^32: 32'hFFFF_FFFC goes to 32'h0000_0000.
- Pop: instr_valid && instr_ready; head advances at the edge. Simultaneous push and pop leaves count unchanged.
- Outputs:
  - instr, instr_pc and instr_valid reflect the registered FIFO head.
  - Latency: a word fetched at pc in cycle N is visible at the outputs in cycle N+1 at the earliest.
  - Throughput is 1 instruction/cycle with instr_ready held high.
- Stability: while instr_valid = 1 and instr_ready = 0, instr and instr_pc must not change unless a redirect occurs.
- Redirect has highest priority:
  - A handshake in the redirect cycle completes normally from decode's view.
  - No push occurs that cycle.
  - At the edge the FIFO is flushed (count = 0) and pc <= redirect_pc, so instr_valid = 0 in cycle N+1.
  - First redirected word is pushed in cycle N+1 and appears in N+2.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - Flushes the FIFO, pc <= redirect_pc, state = HALT.
  - misalign_err <= 1 and stays set until rst; an aligned redirect does not clear it.
- fetch_enable low: no new pushes; existing entries remain poppable; pc stays at the next unfetched address.
- imem_addr is driven every cycle, including IDLE and HALT. Memory reads are side-effect free.
- FIFO: circular buffer with log2(FIFO_DEPTH) read/write pointers plus an explicit count. Full and empty are decoded from count; pointers wrap naturally.

Test Plan:
- Reset then streaming:
  - Stimulus: rst 2 cycles; fetch_enable = 1; instr_ready = 1; memory word k = 32'h1000_0000 + k.
  - Required: instr_pc = 0, 4, 8, … on consecutive cycles; first valid in cycle 2 after rst release; instr = 32'h1000_0000, 32'h1000_0001, ….
- Backpressure:
  - Stimulus: instr_ready = 0 for 5 cycles, with FIFO_DEPTH = 2.
  - Required: count saturates at 2; imem_addr holds at 2; instr/instr_pc are stable at head PC 0.
  - Then release: no lost or duplicated PCs.
- Redirect:
  - Stimulus: redirect_valid pulse with redirect_pc = 32'h0000_0100 while the FIFO holds 2 entries.
  - Required: instr_valid = 0 the next cycle; the following cycle instr_pc = 0x100 with the word at memory[0x40].
- Misaligned redirect:
  - Stimulus: redirect_pc = 32'h0000_0102.
  - Required: misalign_err = 1 next cycle; instr_valid stays 0; imem_addr holds at 0x40.
  - Then aligned redirect to 0x200: fetching resumes at 0x200 and misalign_err stays 1.
- PC wrap:
  - Stimulus: RESET_PC = 32'hFFFF_FFF8, streaming.
  - Required: instr_pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Enable toggle and reset mid-stream:
  - Stimulus: fetch_enable = 0 for 3 cycles with instr_ready = 1.
  - Required: buffer drains to empty; pc is unchanged.
  - Then assert rst while the FIFO is full: next cycle instr_valid = 0 and pc = RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Purpose : instruction-fetch sequencer; owns the PC, drives the imem word address,
//           buffers {pc, word} pairs in a small FIFO and presents the head to decode.
// Latency : a word read at pc in cycle N is at the outputs in cycle N+1 at the earliest;
//           1 instr/cycle sustained.
// Backpr. : instr_ready low stalls the head; fetching pauses when the buffer is full
//           (a same-cycle pop frees the slot).
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   fetch_enable    allow new fetches; when low the buffer still drains
//   redirect_valid  one-cycle redirect pulse, redirect_pc is the byte target
//   imem_rstn       memory reset (~rst)
//   imem_addr       word index into instruction memory, imem_rdata is its data
//   instr_valid     head valid; instr/instr_pc are the head word and its byte PC
//   instr_ready     decode accepts the head
//   misalign_err    sticky flag for a redirect target that is not 4-byte aligned
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_rstn,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic [31:0]   pc_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        head;

    logic full;
    logic space;
    logic pop;
    logic push;
    logic misaligned;

    // ------------------------------------------------------------------
    // Handshake / flow decode
    // ------------------------------------------------------------------
    assign full       = (count == DEPTH_C);
    assign pop        = instr_valid && instr_ready;
    // A pop at the same edge frees the slot the push is about to fill.
    assign space      = !full || pop;
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    // Redirect wins over everything: the word read this cycle belongs to the
    // old stream and must not enter the buffer.
    assign push       = (state == FETCH) && fetch_enable && !redirect_valid && space;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_enable)  state_nxt = FETCH;
            FETCH:   if (!fetch_enable) state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        // A redirect overrides the normal transitions from any state; an
        // aligned one is also the only way out of HALT short of reset.
        if (redirect_valid) begin
            if (misaligned) begin
                state_nxt = HALT;
            end else if (fetch_enable) begin
                state_nxt = FETCH;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // PC and occupancy next values
    // ------------------------------------------------------------------
    always_comb begin
        pc_nxt = pc;
        if (redirect_valid) begin
            pc_nxt = redirect_pc;
        end else if (push) begin
            pc_nxt = pc + 32'd4;        // wraps naturally at 2^32
        end
    end

    always_comb begin
        count_nxt = count;
        if (redirect_valid) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // PC, pointers, count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            pc    <= pc_nxt;
            count <= count_nxt;
            if (redirect_valid) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + PW'(1);
                if (pop)  rptr <= rptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= '{pc: pc, word: imem_rdata};
        end
    end

    // ------------------------------------------------------------------
    // Sticky misalignment flag; only reset clears it
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            misalign_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head        = fifo_mem[rptr];
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.word : 32'h0;
    assign instr_pc    = instr_valid ? head.pc   : 32'h0;

    assign imem_rstn   = ~rst;
    assign imem_addr   = {2'b00, pc[31:2]};

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fe, rv, ready;
    logic [31:0] rpc;
    logic        imem_rstn, instr_valid, misalign_err;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc;

    logic        fe1, ready1;
    logic        imem_rstn1, instr_valid1, misalign_err1;
    logic [31:0] imem_addr1, imem_rdata1, instr1, instr_pc1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata1 = mem_word(imem_addr1);

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .fetch_enable(fe),
        .redirect_valid(rv), .redirect_pc(rpc),
        .imem_rstn(imem_rstn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(ready),
        .instr(instr), .instr_pc(instr_pc), .misalign_err(misalign_err)
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .fetch_enable(fe1),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_rstn(imem_rstn1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .instr_valid(instr_valid1), .instr_ready(ready1),
        .instr(instr1), .instr_pc(instr_pc1), .misalign_err(misalign_err1)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected PCs in fetch order; every handshake pops one.
    logic [31:0] exp_q[$];
    logic [31:0] last_pop = 32'h0;
    int          pops = 0;

    task automatic fill(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        if (!rst && instr_valid && ready) begin
            logic [31:0] e;
            pops++;
            chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc, e);
                chk("sb_word", instr, mem_word(e >> 2));
                last_pop = e;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; fe = 1'b0; rv = 1'b0; ready = 1'b0; rpc = 32'h0;
        fe1 = 1'b0; ready1 = 1'b0;

        // ---------------- reset ----------------
        cyc(); rst = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_vld",   32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    instr_pc, 32'h0);
        chk("rst_merr",  32'(misalign_err), 32'd0);
        chk("rst_rstn",  32'(imem_rstn), 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);

        // ---------------- streaming ----------------
        cyc(); rst = 1'b0; fe = 1'b1; ready = 1'b1;
        exp_q.delete(); fill(32'h0, 32); pops = 0;
        @(negedge clk);
        chk("p1_c0_vld", 32'(instr_valid), 32'd0);
        chk("p1_rstn",   32'(imem_rstn), 32'd1);
        cyc(); @(negedge clk);
        chk("p1_c1_vld", 32'(instr_valid), 32'd0);
        cyc(); @(negedge clk);
        chk("p1_c2_vld", 32'(instr_valid), 32'd1);
        chk("p1_c2_pc",  instr_pc, 32'h0);
        repeat (5) cyc();
        chk("p1_thru", 32'(pops), 32'd5);

        // ---------------- backpressure ----------------
        rst = 1'b1; ready = 1'b0;
        cyc(); rst = 1'b0;
        exp_q.delete(); fill(32'h0, 32); pops = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            if (c >= 2) begin
                chk("p2_hold_vld",  32'(instr_valid), 32'd1);
                chk("p2_hold_pc",   instr_pc, 32'h0);
                chk("p2_hold_word", instr, 32'h1000_0000);
            end
            if (c >= 3) chk("p2_addr", imem_addr, 32'd2);
        end
        cyc(); ready = 1'b1;
        repeat (6) cyc();
        chk("p2_thru", 32'(pops), 32'd6);

        // ---------------- redirect with full buffer ----------------
        ready = 1'b0; rv = 1'b1; rpc = 32'h0000_0100;
        exp_q.delete(); fill(32'h100, 32); pops = 0;
        cyc(); rv = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("p3_n1_vld", 32'(instr_valid), 32'd0);
        cyc(); @(negedge clk);
        chk("p3_n2_vld",  32'(instr_valid), 32'd1);
        chk("p3_n2_pc",   instr_pc, 32'h100);
        chk("p3_n2_word", instr, 32'h1000_0040);
        repeat (3) cyc();
        chk("p3_thru", 32'(pops), 32'd3);

        // ---------------- misaligned redirect ----------------
        rv = 1'b1; rpc = 32'h0000_0102;
        cyc(); rv = 1'b0; exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            chk("p4_merr", 32'(misalign_err), 32'd1);
            chk("p4_vld",  32'(instr_valid), 32'd0);
            chk("p4_addr", imem_addr, 32'h40);
        end
        cyc(); rv = 1'b1; rpc = 32'h0000_0200;
        exp_q.delete(); fill(32'h200, 32); pops = 0;
        @(negedge clk);
        chk("p4_m0_merr", 32'(misalign_err), 32'd1);
        cyc(); rv = 1'b0;
        @(negedge clk);
        chk("p4_m1_vld", 32'(instr_valid), 32'd0);
        cyc(); @(negedge clk);
        chk("p4_m2_vld",  32'(instr_valid), 32'd1);
        chk("p4_m2_pc",   instr_pc, 32'h200);
        chk("p4_m2_merr", 32'(misalign_err), 32'd1);
        repeat (3) cyc();
        chk("p4_thru", 32'(pops), 32'd3);

        // ---------------- enable toggle, then reset while full ----------------
        fe = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            if (c >= 1) begin
                chk("p5_drain_vld", 32'(instr_valid), 32'd0);
                chk("p5_pc_hold",   imem_addr, (last_pop + 32'd4) >> 2);
            end
        end
        cyc(); fe = 1'b1; ready = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("p5_full_vld",  32'(instr_valid), 32'd1);
        chk("p5_full_head", instr_pc, last_pop + 32'd4);
        cyc(); rst = 1'b1; exp_q.delete();
        cyc(); rst = 1'b0; fe = 1'b0;
        @(negedge clk);
        chk("p5_rst_vld",  32'(instr_valid), 32'd0);
        chk("p5_rst_addr", imem_addr, 32'h0);
        chk("p5_rst_pc",   instr_pc, 32'h0);

        // ---------------- PC wrap (second instance) ----------------
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0; fe1 = 1'b1; ready1 = 1'b1;
        @(negedge clk);
        chk("p6_addr0", imem_addr1, 32'h3FFF_FFFE);
        cyc(); cyc();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            @(negedge clk);
            chk("p6_vld",  32'(instr_valid1), 32'd1);
            chk("p6_pc",   instr_pc1, e);
            chk("p6_word", instr1, mem_word(e >> 2));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
